// File: rtl/fetch_pkg.sv
// Shared definitions for the burst fetch buffer.
//   fetch_state_e      : fetch sequencer states
//   SYSBUS_RD_MEM_TAG  : request tag for a memory read
//   ipb / line_bytes   : geometry helpers shared by the top and the bench
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} fetch_state_e;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
    localparam int         SYSBUS_RD_MEM_TAG = (int'(SYSBUS_READ) << 12) | (int'(SYSBUS_MEMORY) << 8);

    // instructions carried by one bus beat
    function automatic int ipb(input int bus_w, input int inst_w);
        return bus_w / inst_w;
    endfunction

    // bytes covered by one full burst
    function automatic int line_bytes(input int beats, input int bus_w);
        return beats * bus_w / 8;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction FIFO holding {pc, inst} pairs.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : drop all entries this cycle (wins over writes and the read)
//   wr_en/wr_pc/wr_inst : up to IPB writes per cycle, compacted in slot order
//   rd_en       : pop the head when rd_valid
//   rd_valid/rd_pc/rd_inst : head entry (zero when empty)
//   free_slots  : DEPTH minus occupancy
module fetch_fifo #(
    parameter int DEPTH = 32,
    parameter int IPB   = 2,
    parameter int IW    = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [IPB-1:0]           wr_en,
    input  logic [IPB-1:0][63:0]     wr_pc,
    input  logic [IPB-1:0][IW-1:0]   wr_inst,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [63:0]              rd_pc,
    output logic [IW-1:0]            rd_inst,
    output logic [AW:0]              free_slots
);

    logic [63:0]   pc_mem   [DEPTH];
    logic [IW-1:0] inst_mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count, wr_cnt;
    logic [IPB-1:0][AW-1:0] wr_addr;

    // Enabled slots land in consecutive entries, skipping disabled ones.
    always_comb begin
        wr_cnt  = '0;
        wr_addr = '0;
        for (int j = 0; j < IPB; j++) begin
            wr_addr[j] = wr_ptr[AW-1:0] + wr_cnt[AW-1:0];
            wr_cnt     = wr_cnt + (AW+1)'(wr_en[j]);
        end
    end

    assign count      = wr_ptr - rd_ptr;
    assign rd_valid   = (count != '0);
    assign free_slots = (AW+1)'(DEPTH) - count;
    assign rd_pc      = rd_valid ? pc_mem[rd_ptr[AW-1:0]]   : '0;
    assign rd_inst    = rd_valid ? inst_mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        for (int j = 0; j < IPB; j++) begin
            if (wr_en[j]) begin
                pc_mem[wr_addr[j]]   <= wr_pc[j];
                inst_mem[wr_addr[j]] <= wr_inst[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + wr_cnt;
            if (rd_en && rd_valid) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/fetch_burst_buffer.sv
// Burst instruction fetch: requests aligned lines on Sysbus, splits each
// beat into instructions, buffers them and hands them to decode.
//   clk, reset, entry         : clock, sync active-high reset, reset PC
//   bus_req*/bus_resp*        : Sysbus read request / response beats
//   inst_valid/inst_ready/inst/inst_pc : decode handshake
//   redirect/redirect_pc      : flush and restart at a new PC
//   halted                    : a zero instruction stopped fetch
module fetch_burst_buffer
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int INST_WIDTH     = 32,
    parameter int BURST_BEATS    = 8,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [INST_WIDTH-1:0]     inst,
    output logic [63:0]               inst_pc,
    input  logic                      redirect,
    input  logic [63:0]               redirect_pc,
    output logic                      halted
);

    localparam int IPB        = ipb(BUS_DATA_WIDTH, INST_WIDTH);
    localparam int LB         = line_bytes(BURST_BEATS, BUS_DATA_WIDTH);
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int INST_BYTES = INST_WIDTH / 8;
    localparam int FAW        = $clog2(FIFO_DEPTH);
    localparam int CW         = $clog2(BURST_BEATS) + 1;
    localparam logic [63:0]  LINE_MASK  = ~(64'(LB) - 64'd1);
    localparam logic [FAW:0] LINE_INSTS = (FAW+1)'(BURST_BEATS * IPB);

    fetch_state_e state;
    logic [63:0]  fetch_pc, line_base;
    logic [CW-1:0] beat_cnt;
    logic [FAW:0] free_slots;
    logic         beat_take, last_beat, zero_seen;
    logic [IPB-1:0] slot_elig, slot_push;
    logic [IPB-1:0][63:0] slot_pc;
    logic [IPB-1:0][INST_WIDTH-1:0] slot_inst;

    wire unused_resptag = ^bus_resptag;

    assign bus_reqtag  = BUS_TAG_WIDTH'(SYSBUS_RD_MEM_TAG);
    assign bus_reqcyc  = (state == REQ);
    assign bus_req     = (state == REQ) ? BUS_DATA_WIDTH'(fetch_pc & LINE_MASK) : '0;
    // DRAIN keeps acking so the bus can finish the burst it already started.
    assign bus_respack = bus_respcyc && (state == RESP || state == DRAIN);
    assign beat_take   = bus_respack;
    assign last_beat   = beat_take && (beat_cnt == CW'(BURST_BEATS - 1));

    // Slot j of the current beat. Slots below fetch_pc (unaligned entry) are
    // skipped; the first zero and everything after it in the beat is dropped.
    always_comb begin
        zero_seen = 1'b0;
        slot_pc   = '0;
        slot_inst = '0;
        slot_elig = '0;
        slot_push = '0;
        for (int j = 0; j < IPB; j++) begin
            slot_pc[j]   = line_base + 64'(beat_cnt) * 64'(BEAT_BYTES) + 64'(j) * 64'(INST_BYTES);
            slot_inst[j] = bus_resp[j*INST_WIDTH +: INST_WIDTH];
            slot_elig[j] = (state == RESP) && bus_respcyc && !halted && (slot_pc[j] >= fetch_pc);
            zero_seen    = zero_seen | (slot_elig[j] && (slot_inst[j] == '0));
            slot_push[j] = slot_elig[j] && !zero_seen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= entry;
            line_base <= '0;
            beat_cnt  <= '0;
            halted    <= 1'b0;
        end else begin
            if (beat_take) beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
            if (zero_seen) halted <= 1'b1;
            case (state)
                IDLE:  if (!halted && free_slots >= LINE_INSTS) state <= REQ;
                REQ:   if (bus_reqack) begin
                           state     <= RESP;
                           line_base <= fetch_pc & LINE_MASK;
                           beat_cnt  <= '0;
                       end
                RESP:  if (last_beat) begin
                           fetch_pc <= line_base + 64'(LB);
                           state    <= IDLE;
                       end
                DRAIN: if (last_beat) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (redirect) begin
                fetch_pc <= redirect_pc;
                halted   <= 1'b0;
                case (state)
                    REQ:     state <= bus_reqack ? DRAIN : IDLE;
                    RESP,
                    DRAIN:   state <= last_beat ? IDLE : DRAIN;
                    default: state <= IDLE;
                endcase
                // an ack in REQ starts a fresh burst count for the drain
                if (state == REQ && bus_reqack) beat_cnt <= '0;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .IPB(IPB), .IW(INST_WIDTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .wr_en      (slot_push),
        .wr_pc      (slot_pc),
        .wr_inst    (slot_inst),
        .rd_en      (inst_ready),
        .rd_valid   (inst_valid),
        .rd_pc      (inst_pc),
        .rd_inst    (inst),
        .free_slots (free_slots)
    );

endmodule

// File: tb/tb_fetch_burst_buffer.sv
module tb_fetch_burst_buffer;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] entry = 64'h0;
    logic        bus_reqcyc, bus_respack, inst_valid, halted;
    logic [63:0] bus_req, inst_pc;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0, bus_respcyc = 1'b0, inst_ready = 1'b0, redirect = 1'b0;
    logic [63:0] bus_resp = 64'h0, redirect_pc = 64'h0;
    logic [12:0] bus_resptag = 13'h0;
    logic [31:0] inst;

    int n_vec = 0, n_err = 0;

    // bus model / scoreboard state
    exp_t        exp_q[$];
    logic [63:0] req_log[$], pop_log[$];
    int          req_beats_log[$];
    logic [63:0] m_pc, burst_addr, zero_addr = '1;
    logic        m_halt = 0, in_burst = 0, discard = 0, gap_en = 0;
    int          beat = 0, ack_wait = 0, cyc = 0, beat_total = 0;
    int          first_beat_cyc = -1, first_valid_cyc = -1;

    fetch_burst_buffer dut (
        .clk(clk), .reset(reset), .entry(entry),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a == zero_addr) return 32'h0;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder plus scoreboard: drives on negedge, samples 2 time
    // units later (well before the next posedge) what that edge will take.
    initial begin : bus_model
        exp_t e;
        logic [63:0] a;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            bus_reqack  = 1'b0;
            bus_respcyc = 1'b0;
            bus_resp    = 64'h0;
            if (!in_burst && bus_reqcyc) begin
                if (ack_wait == 0) bus_reqack = 1'b1;
            end else if (in_burst && !(gap_en && $urandom_range(0, 3) == 0)) begin
                a = burst_addr + 64'(beat * 8);
                bus_respcyc = 1'b1;
                bus_resp    = {word_at(a + 64'd4), word_at(a)};
            end
            #2;
            cyc++;
            if (reset) begin
                in_burst = 0; beat = 0; discard = 0; ack_wait = 0; beat_total = 0;
                exp_q.delete(); req_log.delete(); pop_log.delete(); req_beats_log.delete();
                m_pc = entry; m_halt = 0; first_beat_cyc = -1; first_valid_cyc = -1;
            end else begin
                if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (inst_valid && inst_ready && !redirect) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected_pop: got pc=%h inst=%h, required no instruction", inst_pc, inst);
                    end else begin
                        e = exp_q.pop_front();
                        if (inst_pc !== e.pc || inst !== e.inst) begin
                            n_err++;
                            $display("FAIL sb_pop: got pc=%h inst=%h, required pc=%h inst=%h", inst_pc, inst, e.pc, e.inst);
                        end
                    end
                    pop_log.push_back(inst_pc);
                end
                if (!in_burst && bus_reqcyc && bus_reqack) begin
                    n_vec++;
                    if (bus_req !== (m_pc & ~64'h3F) || bus_reqtag !== 13'h1100) begin
                        n_err++;
                        $display("FAIL sb_req: got addr=%h tag=%h, required addr=%h tag=1100", bus_req, bus_reqtag, m_pc & ~64'h3F);
                    end
                    req_log.push_back(bus_req);
                    req_beats_log.push_back(beat_total);
                    in_burst = 1; beat = 0; burst_addr = bus_req; discard = redirect;
                    ack_wait = $urandom_range(0, 2);
                end else if (!in_burst && bus_reqcyc && ack_wait > 0) begin
                    ack_wait--;
                end else if (in_burst && bus_respcyc && bus_respack) begin
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                    if (!discard && !redirect) begin
                        for (int j = 0; j < 2; j++) begin
                            a = burst_addr + 64'(beat * 8 + j * 4);
                            w = word_at(a);
                            if (!m_halt && a >= m_pc) begin
                                if (w == 32'h0) m_halt = 1;
                                else begin e.pc = a; e.inst = w; exp_q.push_back(e); end
                            end
                        end
                        if (exp_q.size() > 32) begin
                            n_err++;
                            $display("FAIL fifo_overflow: occupancy %0d, required <= 32", exp_q.size());
                        end
                    end
                    if (redirect) discard = 1;
                    if (beat == 7) begin
                        in_burst = 0;
                        if (!discard) m_pc = burst_addr + 64'd64;
                    end
                    beat++;
                    beat_total++;
                end
                if (redirect) begin
                    exp_q.delete();
                    m_pc = redirect_pc;
                    m_halt = 0;
                end
            end
        end
    end

    task automatic apply_reset(input logic [63:0] e, input logic rdy);
        @(negedge clk);
        reset = 1; entry = e; redirect = 0; redirect_pc = 0; inst_ready = rdy;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1; entry = 64'h1000;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({bus_reqcyc, bus_respack, inst_valid, halted} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b, required 0000", {bus_reqcyc, bus_respack, inst_valid, halted});
        end
        n_vec++;
        if (bus_req !== 64'h0 || inst_pc !== 64'h0 || inst !== 32'h0) begin
            n_err++; $display("FAIL reset_data: got req=%h pc=%h inst=%h, required 0", bus_req, inst_pc, inst);
        end
        n_vec++;
        if (bus_reqtag !== 13'h1100) begin
            n_err++; $display("FAIL reset_tag: got %h, required 1100", bus_reqtag);
        end
    endtask

    task automatic test_line;
        int i;
        gap_en = 1;
        apply_reset(64'h1000, 1'b1);
        for (i = 0; i < 400 && !(pop_log.size() >= 16 && req_log.size() >= 2); i++) @(negedge clk);
        #1;
        n_vec++;
        if (i >= 400) begin n_err++; $display("FAIL line_timeout: got %0d pops, required 16", pop_log.size()); end
        n_vec++;
        if (req_log[0] !== 64'h1000 || req_log[1] !== 64'h1040) begin
            n_err++; $display("FAIL line_reqs: got %h %h, required 1000 1040", req_log[0], req_log[1]);
        end
        n_vec++;
        if (pop_log[0] !== 64'h1000 || pop_log[15] !== 64'h103C) begin
            n_err++; $display("FAIL line_pcs: got %h..%h, required 1000..103c", pop_log[0], pop_log[15]);
        end
        n_vec++;
        if (first_valid_cyc - first_beat_cyc !== 1) begin
            n_err++; $display("FAIL line_latency: got %0d cycles, required 1", first_valid_cyc - first_beat_cyc);
        end
        gap_en = 0;
    endtask

    task automatic test_unaligned;
        int i, n;
        apply_reset(64'h1008, 1'b1);
        for (i = 0; i < 300 && pop_log.size() < 15; i++) @(negedge clk);
        #1;
        n = 0;
        for (int k = 0; k < 15; k++) if (pop_log[k] < 64'h1040) n++;
        n_vec++;
        if (req_log[0] !== 64'h1000 || pop_log[0] !== 64'h1008) begin
            n_err++; $display("FAIL unaligned_first: got req=%h pc=%h, required 1000 1008", req_log[0], pop_log[0]);
        end
        n_vec++;
        if (n !== 14) begin n_err++; $display("FAIL unaligned_count: got %0d, required 14", n); end
    endtask

    task automatic test_backpressure;
        apply_reset(64'h1000, 1'b0);
        repeat (200) @(negedge clk);
        #1;
        n_vec++;
        if (req_log.size() !== 2 || inst_valid !== 1'b1 || inst_pc !== 64'h1000) begin
            n_err++; $display("FAIL bp_full: got reqs=%0d valid=%b pc=%h, required 2 1 1000", req_log.size(), inst_valid, inst_pc);
        end
        @(negedge clk); inst_ready = 1;
        repeat (15) @(negedge clk);
        inst_ready = 0;
        repeat (50) @(negedge clk);
        n_vec++;
        if (req_log.size() !== 2) begin n_err++; $display("FAIL bp_15pops: got %0d reqs, required 2", req_log.size()); end
        inst_ready = 1;
        @(negedge clk);
        inst_ready = 0;
        repeat (50) @(negedge clk);
        n_vec++;
        if (req_log.size() !== 3 || req_log[2] !== 64'h1080) begin
            n_err++; $display("FAIL bp_16pops: got %0d reqs last=%h, required 3 1080", req_log.size(), req_log[req_log.size()-1]);
        end
    endtask

    task automatic test_halt;
        zero_addr = 64'h1018;
        apply_reset(64'h1000, 1'b1);
        repeat (150) @(negedge clk);
        #1;
        n_vec++;
        if (halted !== 1'b1 || bus_reqcyc !== 1'b0 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL halt_state: got halted=%b reqcyc=%b valid=%b, required 1 0 0", halted, bus_reqcyc, inst_valid);
        end
        n_vec++;
        if (pop_log.size() !== 6 || pop_log[5] !== 64'h1014) begin
            n_err++; $display("FAIL halt_pops: got %0d last=%h, required 6 1014", pop_log.size(), pop_log[5]);
        end
        n_vec++;
        if (req_log.size() !== 1 || beat_total !== 8) begin
            n_err++; $display("FAIL halt_bus: got reqs=%0d beats=%0d, required 1 8", req_log.size(), beat_total);
        end
        zero_addr = '1;
    endtask

    task automatic test_redirect;
        int i;
        apply_reset(64'h1000, 1'b0);
        for (i = 0; i < 100 && !(in_burst && beat == 2 && bus_respcyc); i++) begin
            @(negedge clk); #1;
        end
        n_vec++;
        if (i >= 100 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL redir_setup: got valid=%b wait=%0d, required valid 1 at beat 2", inst_valid, i);
        end
        redirect = 1; redirect_pc = 64'h2004;
        @(negedge clk); #1;
        n_vec++;
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got valid=%b, required 0", inst_valid); end
        redirect = 0;
        inst_ready = 1;
        for (i = 0; i < 300 && !(req_log.size() >= 2 && pop_log.size() >= 1); i++) @(negedge clk);
        #1;
        n_vec++;
        if (req_log[1] !== 64'h2000 || req_beats_log[1] !== 8) begin
            n_err++; $display("FAIL redir_req: got %h after %0d beats, required 2000 after 8", req_log[1], req_beats_log[1]);
        end
        n_vec++;
        if (pop_log[0] !== 64'h2004) begin n_err++; $display("FAIL redir_pc: got %h, required 2004", pop_log[0]); end
    endtask

    task automatic test_reset_mid;
        int i;
        apply_reset(64'h1000, 1'b0);
        for (i = 0; i < 100 && !(in_burst && beat == 3 && bus_respcyc); i++) begin
            @(negedge clk); #1;
        end
        reset = 1; entry = 64'h3000;
        @(negedge clk); #1;
        n_vec++;
        if ({bus_reqcyc, bus_respack, inst_valid, halted} !== 4'b0 || bus_req !== 64'h0 || inst_pc !== 64'h0) begin
            n_err++; $display("FAIL midreset_out: got ctl=%b req=%h pc=%h, required 0", {bus_reqcyc, bus_respack, inst_valid, halted}, bus_req, inst_pc);
        end
        reset = 0;
        for (i = 0; i < 100 && req_log.size() < 1; i++) @(negedge clk);
        #1;
        n_vec++;
        if (req_log[0] !== 64'h3000) begin n_err++; $display("FAIL midreset_req: got %h, required 3000", req_log[0]); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_unaligned();
        test_backpressure();
        test_halt();
        test_redirect();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
